// File: rtl/mmu_pkg.sv
// Shared definitions for the systolic-array MMU sequencer: FSM states,
// default geometry and address-width helpers.
package mmu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_N     = 16;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned PERF_W    = 32;

  // Address width for a range of n entries; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmu_seq_perf.sv
// Saturating busy/stall cycle counters for the MMU sequencer, cleared on
// reset or when a new job is accepted.
module mmu_seq_perf
  import mmu_pkg::*;
#(
  parameter int unsigned W = PERF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         busy,
  input  logic         stall,
  output logic [W-1:0] busy_cyc,
  output logic [W-1:0] stall_cyc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      busy_cyc  <= '0;
      stall_cyc <= '0;
    end else begin
      if (busy && (busy_cyc != '1)) begin
        busy_cyc <= busy_cyc + 1'b1;
      end
      if (stall && (stall_cyc != '1)) begin
        stall_cyc <= stall_cyc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmu_sequencer.sv
// Job sequencer for an N x N systolic array: weight load, streamed compute,
// zero-fed drain and result capture. Define MMU_SEQ_PERF_EN for perf counters.
module mmu_sequencer
  import mmu_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           data_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           wwrite,
  output logic                           w_rd_en,
  output logic [addr_w(N)-1:0]           w_addr,
  output logic                           active,
  output logic                           data_rd_en,
  output logic [addr_w(DEPTH)-1:0]       data_addr,
  output logic                           data_zero,
  output logic                           res_wr_en,
  output logic [addr_w(DEPTH+N)-1:0]     res_addr,
  output logic [PERF_W-1:0]              perf_busy_cyc,
  output logic [PERF_W-1:0]              perf_stall_cyc
);

  localparam int unsigned WW = addr_w(N);
  localparam int unsigned DW = addr_w(DEPTH);
  localparam int unsigned RW = addr_w(DEPTH + N);
  localparam int unsigned T  = DEPTH + 2 * N - 1;
  localparam int unsigned KW = addr_w(DEPTH + 2 * N);

  state_t          state, state_n;
  logic [KW-1:0]   k, k_n, kres;
  logic [WW-1:0]   widx, widx_n;

  logic            busy_n, done_n, wwrite_n, w_rd_en_n;
  logic [WW-1:0]   w_addr_n;
  logic            active_n, data_rd_en_n, data_zero_n, res_wr_en_n;
  logic [DW-1:0]   data_addr_n;
  logic [RW-1:0]   res_addr_n;

  // Next state and counters advance on what the current (registered) outputs
  // presented; the outputs for the next cycle are then derived from the new
  // state, so data_valid sampled at an edge sets active for the following cycle.
  always_comb begin
    state_n      = state;
    k_n          = k;
    widx_n       = widx;
    kres         = '0;
    busy_n       = 1'b0;
    done_n       = 1'b0;
    wwrite_n     = 1'b0;
    w_rd_en_n    = 1'b0;
    w_addr_n     = '0;
    active_n     = 1'b0;
    data_rd_en_n = 1'b0;
    data_addr_n  = '0;
    data_zero_n  = 1'b0;
    res_wr_en_n  = 1'b0;
    res_addr_n   = '0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_LOAD_W;
          widx_n  = WW'(N - 1);
          k_n     = '0;
        end
      end
      ST_LOAD_W: begin
        if (widx == '0) begin
          state_n = ST_COMPUTE;
          k_n     = '0;
        end else begin
          widx_n = widx - 1'b1;
        end
      end
      ST_COMPUTE: begin
        if (active) begin
          k_n = k + 1'b1;
          if (k == KW'(DEPTH - 1)) begin
            state_n = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (k == KW'(T - 1)) begin
          state_n = ST_DONE;
        end else begin
          k_n = k + 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    kres   = k_n - KW'(N);
    busy_n = (state_n != ST_IDLE);

    case (state_n)
      ST_LOAD_W: begin
        wwrite_n  = 1'b1;
        w_rd_en_n = 1'b1;
        w_addr_n  = widx_n;
      end
      ST_COMPUTE: begin
        active_n     = data_valid;
        data_rd_en_n = data_valid;
        data_addr_n  = k_n[DW-1:0];
        if (data_valid && (k_n >= KW'(N))) begin
          res_wr_en_n = 1'b1;
          res_addr_n  = kres[RW-1:0];
        end
      end
      ST_DRAIN: begin
        active_n    = 1'b1;
        data_zero_n = 1'b1;
        if (k_n >= KW'(N)) begin
          res_wr_en_n = 1'b1;
          res_addr_n  = kres[RW-1:0];
        end
      end
      ST_DONE: done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      k          <= '0;
      widx       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wwrite     <= 1'b0;
      w_rd_en    <= 1'b0;
      w_addr     <= '0;
      active     <= 1'b0;
      data_rd_en <= 1'b0;
      data_addr  <= '0;
      data_zero  <= 1'b0;
      res_wr_en  <= 1'b0;
      res_addr   <= '0;
    end else begin
      state      <= state_n;
      k          <= k_n;
      widx       <= widx_n;
      busy       <= busy_n;
      done       <= done_n;
      wwrite     <= wwrite_n;
      w_rd_en    <= w_rd_en_n;
      w_addr     <= w_addr_n;
      active     <= active_n;
      data_rd_en <= data_rd_en_n;
      data_addr  <= data_addr_n;
      data_zero  <= data_zero_n;
      res_wr_en  <= res_wr_en_n;
      res_addr   <= res_addr_n;
    end
  end

`ifdef MMU_SEQ_PERF_EN
  logic perf_clear, perf_stall;

  assign perf_clear = (state == ST_IDLE) && start;
  // A stall is a presented COMPUTE cycle that did not advance the array.
  assign perf_stall = (state == ST_COMPUTE) && !active;

  mmu_seq_perf #(
    .W(PERF_W)
  ) u_perf (
    .clk       (clk),
    .reset     (reset),
    .clear     (perf_clear),
    .busy      (busy),
    .stall     (perf_stall),
    .busy_cyc  (perf_busy_cyc),
    .stall_cyc (perf_stall_cyc)
  );
`else
  assign perf_busy_cyc  = '0;
  assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_mmu_sequencer.sv
// Scoreboard bench for mmu_sequencer (N=4, DEPTH=4): a job-level model builds
// the expected per-cycle trace; a monitor pops and compares on busy cycles.
module tb_mmu_sequencer;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned T     = DEPTH + 2 * N - 1;
  localparam int unsigned WW    = $clog2(N);
  localparam int unsigned DW    = $clog2(DEPTH);
  localparam int unsigned RW    = $clog2(DEPTH + N);

  logic          clk = 1'b0;
  logic          reset, start, data_valid;
  logic          busy, done, wwrite, w_rd_en, active, data_rd_en, data_zero, res_wr_en;
  logic [WW-1:0] w_addr;
  logic [DW-1:0] data_addr;
  logic [RW-1:0] res_addr;
  logic [31:0]   perf_busy_cyc, perf_stall_cyc;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          wwrite;
    logic          w_rd_en;
    logic [WW-1:0] w_addr;
    logic          active;
    logic          data_rd_en;
    logic [DW-1:0] data_addr;
    logic          data_zero;
    logic          res_wr_en;
    logic [RW-1:0] res_addr;
    logic [31:0]   pb;
    logic [31:0]   ps;
  } vec_t;

  vec_t        sb[$];
  vec_t        job[$];
  bit          jcomp[$];
  int          jk[$];
  int unsigned stl[DEPTH];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          mon_en   = 1'b0;

  mmu_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .data_valid     (data_valid),
    .busy           (busy),
    .done           (done),
    .wwrite         (wwrite),
    .w_rd_en        (w_rd_en),
    .w_addr         (w_addr),
    .active         (active),
    .data_rd_en     (data_rd_en),
    .data_addr      (data_addr),
    .data_zero      (data_zero),
    .res_wr_en      (res_wr_en),
    .res_addr       (res_addr),
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc)
  );

  always #5 clk = ~clk;

  function automatic vec_t actual();
    vec_t v;
    v.busy = busy; v.done = done; v.wwrite = wwrite; v.w_rd_en = w_rd_en;
    v.w_addr = w_addr; v.active = active; v.data_rd_en = data_rd_en;
    v.data_addr = data_addr; v.data_zero = data_zero; v.res_wr_en = res_wr_en;
    v.res_addr = res_addr; v.pb = perf_busy_cyc; v.ps = perf_stall_cyc;
    return v;
  endfunction

  task automatic check_vec(input string name, input vec_t a, input vec_t e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, a, e);
  endtask

  task automatic check_int(input string name, input int unsigned a, input int unsigned e);
    n_checks++;
    if (a == e) n_pass++;
    else $display("FAIL %s @%0t: got %0d expected %0d", name, $time, a, e);
  endtask

  // Monitor: every busy cycle consumes one expected entry; idle cycles must be quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      vec_t a, e;
      a = actual();
      if (a.busy) begin
        if (sb.size() == 0) check_int("unexpected_busy", 1, 0);
        else begin
          e = sb.pop_front();
          check_vec("cycle", a, e);
        end
      end else begin
        a.pb = '0;
        a.ps = '0;
        check_vec("idle_outputs", a, '0);
      end
    end
  end

  function automatic vec_t blank(input int unsigned idx, input int unsigned nst);
    vec_t v;
    v = '0;
    v.busy = 1'b1;
`ifdef MMU_SEQ_PERF_EN
    v.pb = 32'(idx);
    v.ps = 32'(nst);
`else
    if (idx == 0 && nst == 0) v.pb = '0;
`endif
    return v;
  endfunction

  function automatic vec_t with_res(input vec_t vi, input int unsigned k);
    vec_t v;
    v = vi;
    if (k >= N) begin
      v.res_wr_en = 1'b1;
      v.res_addr  = RW'(k - N);
    end
    return v;
  endfunction

  task automatic add(input vec_t v, input bit c, input int kk);
    job.push_back(v);
    jcomp.push_back(c);
    jk.push_back(kk);
  endtask

  // Expected job trace: N weight rows bottom-first, DEPTH input rows each
  // preceded by its stall cycles, 2N-1 drain cycles, then one done cycle.
  task automatic build_job();
    vec_t v;
    int unsigned ns = 0;
    job.delete(); jcomp.delete(); jk.delete();
    for (int unsigned i = 0; i < N; i++) begin
      v = blank(job.size(), ns);
      v.wwrite = 1'b1; v.w_rd_en = 1'b1; v.w_addr = WW'(N - 1 - i);
      add(v, 1'b0, -1);
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      for (int unsigned s = 0; s < stl[k]; s++) begin
        v = blank(job.size(), ns);
        v.data_addr = DW'(k);
        add(v, 1'b1, -1);
        ns++;
      end
      v = blank(job.size(), ns);
      v.active = 1'b1; v.data_rd_en = 1'b1; v.data_addr = DW'(k);
      add(with_res(v, k), 1'b1, int'(k));
    end
    for (int unsigned k = DEPTH; k < T; k++) begin
      v = blank(job.size(), ns);
      v.active = 1'b1; v.data_zero = 1'b1;
      add(with_res(v, k), 1'b0, int'(k));
    end
    v = blank(job.size(), ns);
    v.done = 1'b1;
    add(v, 1'b0, -1);
  endtask

  task automatic step(input logic s, input logic dv, input logic r);
    @(posedge clk);
    #2;
    start = s; data_valid = dv; reset = r;
  endtask

  task automatic run_job(input int abort_k, input bit drain_dv0);
    logic dv;
    bit aborted = 1'b0;
    build_job();
    for (int e = 0; e < job.size(); e++) begin
      if (abort_k >= 0 && e > 0 && jk[e-1] == abort_k) begin
        step(1'b0, 1'b0, 1'b1);
        aborted = 1'b1;
        break;
      end
      if (jcomp[e]) dv = job[e].active;
      else dv = drain_dv0 ? 1'b0 : 1'($urandom_range(0, 1));
      step((e == 0) ? 1'b1 : 1'($urandom_range(0, 1)), dv, 1'b0);
      sb.push_back(job[e]);
    end
    if (aborted) begin
      step(1'b0, 1'b0, 1'b0);
      check_vec("after_reset", actual(), '0);
    end else begin
      step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  task automatic rand_stalls();
    for (int unsigned k = 0; k < DEPTH; k++)
      stl[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data_valid = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check_vec("reset_state", actual(), '0);
    mon_en = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    foreach (stl[k]) stl[k] = 0;
    run_job(-1, 1'b1);
    stl[2] = 3;
    run_job(-1, 1'b0);
    rand_stalls();
    run_job(-1, 1'b0);
    rand_stalls();
    run_job(5, 1'b0);
    foreach (stl[k]) stl[k] = 0;
    run_job(-1, 1'b0);
    for (int j = 0; j < 16; j++) begin
      int unsigned gap = $urandom_range(0, 2);
      for (int unsigned g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      rand_stalls();
      run_job(-1, 1'b0);
    end

    repeat (3) step(1'b0, 1'b0, 1'b0);
    check_int("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mmu_sequencer.md
MMU_SEQUENCER -- requirements
Module: mmu_sequencer

Interface
REQ-001 Parameter N, default 16: systolic array dimension (N x N pe_with_dsp_mult tiles), N >= 2.
REQ-002 Parameter DEPTH, default 16: input-matrix rows streamed per job, DEPTH >= 1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  job request, sampled only in IDLE.
REQ-006 data_valid  in  1  input-row source has a row available this cycle.
REQ-007 busy  out  1  high in any state other than IDLE.
REQ-008 done  out  1  one-cycle pulse when a job completes.
REQ-009 wwrite  out  1  weight-shift enable into array top row.
REQ-010 w_rd_en / w_addr  out  1 / clog2(N)  weight-row read strobe and index.
REQ-011 active  out  1  array advance enable; low stalls every PE.
REQ-012 data_rd_en / data_addr  out  1 / clog2(DEPTH)  input-row read strobe and index.
REQ-013 data_zero  out  1  feeder injects zeros (drain bubbles).
REQ-014 res_wr_en / res_addr  out  1 / clog2(DEPTH+N)  result-row capture strobe and index.
REQ-015 perf_busy_cyc, perf_stall_cyc  out  32 each  performance counters (see Configuration).

Function
REQ-016 FSM states IDLE, LOAD_W, COMPUTE, DRAIN, DONE; all outputs registered.
REQ-017 IDLE -> LOAD_W on start=1; start in any other state is ignored, no queuing.
REQ-018 LOAD_W: exactly N cycles, w_rd_en=wwrite=1, w_addr = N-1 down to 0 (bottom row shifted in first); not stallable; then -> COMPUTE.
REQ-019 Active-cycle counter k (0-based) increments only on cycles with active=1; total job length T = DEPTH+2N-1 active cycles.
REQ-020 COMPUTE (k < DEPTH): active=data_rd_en=data_valid, data_addr=k, data_zero=0; data_valid=0 gives active=0 and holds k (stall).
REQ-021 COMPUTE -> DRAIN after the active cycle with k = DEPTH-1.
REQ-022 DRAIN (DEPTH <= k < T): active=1, data_zero=1, data_rd_en=0, data_valid ignored.
REQ-023 res_wr_en=1 on active cycles with N <= k <= T-1, res_addr = k-N (DEPTH+N-1 result rows; skewed, deskew is downstream).
REQ-024 DRAIN -> DONE after active cycle k = T-1; DONE lasts one cycle with done=1, busy=1, then -> IDLE.
REQ-025 wwrite=0 outside LOAD_W; active=0 in IDLE, LOAD_W, DONE.
REQ-026 Back-to-back jobs: start on the first IDLE cycle after DONE is accepted; no extra gap required.

Reset
REQ-027 reset=1 forces IDLE on the next edge, clears k, all address counters and perf counters; every output 0.
REQ-028 reset mid-job (any state) aborts with no done pulse; array contents are not cleared by this block.

Configuration
REQ-029 Macro MMU_SEQ_PERF_EN: defined -> perf_busy_cyc counts cycles with busy=1, perf_stall_cyc counts COMPUTE cycles with data_valid=0, both saturating at 2^32-1, cleared on accepted start.
REQ-030 Without MMU_SEQ_PERF_EN: ports present, tied to 0, no counter flops.

Structure
REQ-031 Shared package mmu_pkg: FSM state enum, default N/DEPTH constants, derived-width helpers.
REQ-032 One sub-module mmu_seq_perf (performance counters), instantiated only under MMU_SEQ_PERF_EN.

Verification
REQ-033 N=4, DEPTH=4, data_valid=1, start pulse -> 4 wwrite cycles w_addr 3,2,1,0; 11 active cycles; res_wr_en on k=4..10, res_addr 0..6; done 1 cycle later.
REQ-034 Same job, data_valid=0 for 3 cycles at k=2 -> active low 3 cycles, data_addr holds 2, total job +3 cycles, perf_stall_cyc=3 (macro on).
REQ-035 data_valid=0 throughout DRAIN -> no stall, DRAIN length 7 cycles unchanged.
REQ-036 start pulsed during COMPUTE and DONE -> ignored; start on first IDLE cycle -> new LOAD_W next cycle.
REQ-037 reset asserted at k=5 -> next cycle IDLE, all outputs 0, no done; new start runs a full clean job.
REQ-038 Build without MMU_SEQ_PERF_EN -> perf outputs constant 0, REQ-033 timing identical.
